// File: rtl/ecs_frame_pkg.sv
// Frame-format constants and FSM state encoding shared by the rx_bridge / tx_bridge pair.
// A frame is HEADER, D1..D4, then the mod-256 sum of D1..D4.
package ecs_frame_pkg;

   localparam logic [7:0] FRAME_HEADER = 8'hAA;
   localparam int         FRAME_LEN    = 6;
   localparam int         PAYLOAD_LEN  = 4;

   typedef logic [2:0] byte_idx_t;
   localparam byte_idx_t LAST_IDX = 3'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GAP_WAIT  = 3'd1,
      ST_SEND      = 3'd2,
      ST_HOLD      = 3'd3,
      ST_WAIT_IDLE = 3'd4,
      ST_DONE      = 3'd5
   } frame_state_e;

endpackage

// File: rtl/frame_checksum.sv
// Combinational mod-256 sum of the four payload bytes; also used on the rx_bridge check path.
module frame_checksum (
   input  logic [7:0] d1_i,
   input  logic [7:0] d2_i,
   input  logic [7:0] d3_i,
   input  logic [7:0] d4_i,
   output logic [7:0] sum_o
);

   // The 8-bit result width performs the mod-256 wrap.
   assign sum_o = d1_i + d2_i + d3_i + d4_i;

endmodule

// File: rtl/tx_bridge.sv
// Transmit framer: turns a latched 4-byte payload into six txen/txdb byte strobes
// (header, payload, checksum) paced by the UART's tx_idle and a minimum inter-byte gap.
module tx_bridge
   import ecs_frame_pkg::*;
#(
   parameter logic [7:0]  HEADER = FRAME_HEADER,
   parameter int unsigned GAP    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       TX_req,
   input  logic [7:0] Data1,
   input  logic [7:0] Data2,
   input  logic [7:0] Data3,
   input  logic [7:0] Data4,
   input  logic       tx_idle,
   output logic       txen,
   output logic [7:0] txdb,
   output logic       TX_busy,
   output logic       TX_done
);

   // The SEND cycle itself is the last gap cycle, so GAP_WAIT runs GAP-1 cycles and
   // strobes land exactly GAP+2 cycles apart when the UART never stalls.
   localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
   localparam bit         GAP_SKIP = (GAP < 2);

   frame_state_e state_q;
   byte_idx_t    idx_q;
   logic [7:0]   gap_q;
   logic [7:0]   d1_q, d2_q, d3_q, d4_q;
   logic [7:0]   csum_q;
   logic         txen_q;
   logic [7:0]   txdb_q;
   logic         busy_q;
   logic         done_q;

   logic [7:0]   csum;
   logic [7:0]   cur_byte;

   frame_checksum u_checksum (
      .d1_i  (Data1),
      .d2_i  (Data2),
      .d3_i  (Data3),
      .d4_i  (Data4),
      .sum_o (csum)
   );

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cur_byte = HEADER;
      case (idx_q)
         3'd1:    cur_byte = d1_q;
         3'd2:    cur_byte = d2_q;
         3'd3:    cur_byte = d3_q;
         3'd4:    cur_byte = d4_q;
         3'd5:    cur_byte = csum_q;
         default: cur_byte = HEADER;
      endcase
   end

   // NOTE: the payload registers are small flops, not RAM, so clearing them in reset is cheap and keeps txdb deterministic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         d4_q    <= '0;
         csum_q  <= '0;
         txen_q  <= 1'b0;
         txdb_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only here, so every branch reads pre-edge state.
         case (state_q)
            ST_IDLE: begin
               if (TX_req) begin
                  d1_q    <= Data1;
                  d2_q    <= Data2;
                  d3_q    <= Data3;
                  d4_q    <= Data4;
                  csum_q  <= csum;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_idle) begin
                  txen_q  <= 1'b1;
                  txdb_q  <= cur_byte;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // tx_idle is not trusted here: the UART needs a cycle to report busy.
               txen_q  <= 1'b0;
               state_q <= ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
               if (tx_idle) begin
                  if (idx_q == LAST_IDX) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     gap_q   <= GAP_LOAD;
                     state_q <= GAP_SKIP ? ST_SEND : ST_GAP_WAIT;
                  end
               end
            end
            ST_GAP_WAIT: begin
               if (gap_q <= 8'd1) begin
                  gap_q   <= '0;
                  state_q <= ST_SEND;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign txen    = txen_q;
   assign txdb    = txdb_q;
   assign TX_busy = busy_q;
   assign TX_done = done_q;

endmodule

// File: tb/tb_tx_bridge.sv
// Self-checking bench for tx_bridge: directed and randomized frames compared against a
// frame model built from the header/payload/checksum rules.
module tb_tx_bridge;

   localparam int GAP     = 8;
   localparam int BP_LEN  = 20;
   localparam int MAX_CYC = 3000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       TX_req = 1'b0;
   logic [7:0] Data1 = '0, Data2 = '0, Data3 = '0, Data4 = '0;
   logic       tx_idle = 1'b1;
   logic       txen;
   logic [7:0] txdb;
   logic       TX_busy;
   logic       TX_done;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   tx_bridge #(.HEADER(8'hAA), .GAP(GAP)) dut (
      .clk     (clk),
      .rst     (rst),
      .TX_req  (TX_req),
      .Data1   (Data1),
      .Data2   (Data2),
      .Data3   (Data3),
      .Data4   (Data4),
      .tx_idle (tx_idle),
      .txen    (txen),
      .txdb    (txdb),
      .TX_busy (TX_busy),
      .TX_done (TX_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_min(input string tag, input int obs, input int min_val);
      n_checks++;
      assert (obs >= min_val) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d expected at least %0d", tag, obs, min_val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference frame: header, the four bytes in order, then their sum modulo 256.
   function automatic logic [7:0] model_byte(input logic [31:0] d, input int i);
      int sum;
      sum = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
      case (i)
         0:       return 8'hAA;
         1:       return d[31:24];
         2:       return d[23:16];
         3:       return d[15:8];
         4:       return d[7:0];
         default: return 8'(sum % 256);
      endcase
   endfunction

   task automatic run_frame(input string tag, input logic [31:0] d, input bit bp,
                            input bit mid_req, input int abort_after);
      logic [7:0] got[$];
      int         stamp[$];
      int         acc, bp_left, extra;
      bit         done_seen, busy_ok, mid_sent, aborted;
      logic       busy_at_done;

      {Data1, Data2, Data3, Data4} = d;
      TX_req = 1'b1;
      tick();
      acc    = cyc;
      TX_req = 1'b0;
      bp_left = 0; done_seen = 0; busy_ok = 1; mid_sent = 0; aborted = 0;
      busy_at_done = 1'bx;

      for (int k = 0; k < MAX_CYC; k++) begin
         TX_req = 1'b0;
         if (txen === 1'b1) begin
            got.push_back(txdb);
            stamp.push_back(cyc);
            if (bp) begin
               tx_idle = 1'b0;
               bp_left = BP_LEN;
            end
         end else if (bp_left > 0) begin
            bp_left--;
            if (bp_left == 0) tx_idle = 1'b1;
         end
         if (TX_done === 1'b1) begin
            done_seen    = 1;
            busy_at_done = TX_busy;
            break;
         end
         if (TX_busy !== 1'b1) busy_ok = 0;
         if (abort_after > 0 && got.size() == abort_after) begin
            aborted = 1;
            break;
         end
         if (mid_req) begin
            if (got.size() == 2 && !mid_sent) begin
               {Data1, Data2, Data3, Data4} = 32'h11223344;
               TX_req   = 1'b1;
               mid_sent = 1;
            end
         end else begin
            {Data1, Data2, Data3, Data4} = $urandom;
         end
         tick();
      end
      tx_idle = 1'b1;

      if (aborted) begin
         rst = 1'b0;
         #1;
         check({tag, "_rst_txen"}, txen, 1'b0);
         check({tag, "_rst_txdb"}, txdb, 8'h00);
         check({tag, "_rst_busy"}, TX_busy, 1'b0);
         check({tag, "_rst_done"}, TX_done, 1'b0);
         tick();
         tick();
         rst = 1'b1;
         extra = 0;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (txen !== 1'b0 || TX_done !== 1'b0 || TX_busy !== 1'b0) extra++;
         end
         check({tag, "_quiet_after_abort"}, extra, 0);
         return;
      end

      check({tag, "_done_seen"}, done_seen, 1'b1);
      check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
      check({tag, "_busy_held"}, busy_ok, 1'b1);
      check({tag, "_strobes"}, got.size(), 6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got[i], model_byte(d, i));
      if (stamp.size() > 0) check({tag, "_latency"}, stamp[0] - acc, 1);
      for (int i = 1; i < stamp.size(); i++) begin
         if (bp) check_min($sformatf("%s_space%0d", tag, i), stamp[i] - stamp[i-1], BP_LEN + GAP);
         else    check($sformatf("%s_space%0d", tag, i), stamp[i] - stamp[i-1], GAP + 2);
      end

      // A request raised while DONE is showing must be dropped.
      TX_req = 1'b1;
      tick();
      TX_req = 1'b0;
      check({tag, "_done_pulse_len"}, TX_done, 1'b0);
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         if (txen !== 1'b0 || TX_busy !== 1'b0) extra++;
         tick();
      end
      check({tag, "_no_extra_frame"}, extra, 0);
   endtask

   initial begin
      rst = 1'b0;
      tick();
      check("reset_txen", txen, 1'b0);
      check("reset_txdb", txdb, 8'h00);
      check("reset_busy", TX_busy, 1'b0);
      check("reset_done", TX_done, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      run_frame("basic", 32'h04020100, 1'b0, 1'b0, 0);
      run_frame("wrap", 32'hFFFF0100, 1'b0, 1'b0, 0);
      run_frame("backpressure", $urandom, 1'b1, 1'b0, 0);
      run_frame("busy_req", $urandom, 1'b0, 1'b1, 0);
      run_frame("after_busy", 32'h11223344, 1'b0, 1'b0, 0);
      run_frame("abort", $urandom, 1'b0, 1'b0, 3);
      run_frame("post_abort", $urandom, 1'b0, 1'b0, 0);
      for (int f = 0; f < 4; f++)
         run_frame($sformatf("rand%0d", f), $urandom, 1'($urandom_range(0, 1)), 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
